// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 encodings, FSM states, lane masks.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    // Lane mask bit3 is byte offset 0; masks are shifted right by the byte offset.
    localparam logic [MASK_W-1:0] LANE_MASK_B = 4'b1000;
    localparam logic [MASK_W-1:0] LANE_MASK_H = 4'b1100;
    localparam logic [MASK_W-1:0] LANE_MASK_W = 4'b1111;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } lsu_state_e;

    // Unsigned variants only make sense for loads.
    function automatic logic funct3_legal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response and RAM port B signal bundle for the LSU.
interface lsu_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  mem_en;
    logic [3:0]            mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    // Core side drives requests and accepts responses; RAM side returns read data.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Store lane placement/mask and load byte/halfword extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        i_st_funct3,
    input  logic [1:0]        i_st_off,
    input  logic [DATA_W-1:0] i_st_wdata,
    output logic [MASK_W-1:0] o_st_mask_c,
    output logic [DATA_W-1:0] o_st_data_c,
    input  logic [2:0]        i_ld_funct3,
    input  logic [1:0]        i_ld_off,
    input  logic [DATA_W-1:0] i_ld_word,
    output logic [DATA_W-1:0] o_ld_data_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Sub-word stores replicate the data so every lane carries it; the mask picks the lane.
    always_comb begin
        o_st_mask_c = '0;
        o_st_data_c = i_st_wdata;
        case (i_st_funct3)
            F3_B, F3_BU: begin
                o_st_mask_c = LANE_MASK_B >> i_st_off;
                o_st_data_c = {4{i_st_wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                o_st_mask_c = i_st_off[1] ? (LANE_MASK_H >> 2) : LANE_MASK_H;
                o_st_data_c = {2{i_st_wdata[15:0]}};
            end
            F3_W:    o_st_mask_c = LANE_MASK_W;
            default: o_st_mask_c = '0;
        endcase
    end

    always_comb begin
        case (i_ld_off)
            2'd0:    w_byte = i_ld_word[7:0];
            2'd1:    w_byte = i_ld_word[15:8];
            2'd2:    w_byte = i_ld_word[23:16];
            default: w_byte = i_ld_word[31:24];
        endcase
        w_half = i_ld_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];
    end

    always_comb begin
        o_ld_data_c = '0;
        case (i_ld_funct3)
            F3_B:    o_ld_data_c = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_ld_data_c = {24'd0, w_byte};
            F3_H:    o_ld_data_c = {{16{w_half[15]}}, w_half};
            F3_HU:   o_ld_data_c = {16'd0, w_half};
            F3_W:    o_ld_data_c = i_ld_word;
            default: o_ld_data_c = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: core request -> single RAM port B access -> formatted response.
// Build option LSU_MISALIGN_TRAP_EN: reject misaligned accesses instead of aligning them down.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  mem_en_o,
    output logic [MASK_W-1:0]     mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    lsu_state_e            r_state;
    logic                  r_ready;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [1:0]            r_off;
    logic                  r_mem_en;
    logic [MASK_W-1:0]     r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [DATA_W-1:0]     r_rsp_rdata;

    logic                  w_misalign;
    logic                  w_reject;
    logic [ADDR_WIDTH-1:0] w_addr_fix;
    logic [MASK_W-1:0]     w_st_mask;
    logic [DATA_W-1:0]     w_st_data;
    logic [DATA_W-1:0]     w_ld_data;

    assign w_misalign = addr_misaligned(req_funct3_i, req_addr_i[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_reject   = !funct3_legal(req_funct3_i, req_we_i) || w_misalign;
    assign w_addr_fix = req_addr_i;
`else
    assign w_reject = !funct3_legal(req_funct3_i, req_we_i);

    // Misaligned accesses are silently aligned down to the natural boundary.
    always_comb begin
        w_addr_fix = req_addr_i;
        if (w_misalign) begin
            if (req_funct3_i == F3_W) w_addr_fix[1:0] = 2'b00;
            else                      w_addr_fix[0]   = 1'b0;
        end
    end
`endif

    lsu_align u_align (
        .i_st_funct3 (req_funct3_i),
        .i_st_off    (w_addr_fix[1:0]),
        .i_st_wdata  (req_wdata_i),
        .o_st_mask_c (w_st_mask),
        .o_st_data_c (w_st_data),
        .i_ld_funct3 (r_funct3),
        .i_ld_off    (r_off),
        .i_ld_word   (mem_rdata_i),
        .o_ld_data_c (w_ld_data)
    );

    // RAM strobes are set on entry to ACCESS so they are high exactly while in ACCESS.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_funct3    <= '0;
            r_off       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= '0;
            unique case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (req_valid_i && r_ready) begin
                        r_ready     <= 1'b0;
                        r_we        <= req_we_i;
                        r_funct3    <= req_funct3_i;
                        r_off       <= w_addr_fix[1:0];
                        r_mem_addr  <= {w_addr_fix[ADDR_WIDTH-1:2], 2'b00};
                        r_mem_wdata <= req_we_i ? w_st_data : '0;
                        if (w_reject) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state  <= S_ACCESS;
                            r_mem_en <= 1'b1;
                            r_mem_we <= req_we_i ? w_st_mask : '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_we) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= w_ld_data;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= S_IDLE;
                        r_ready     <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o = r_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_rdata_o = r_rsp_rdata;
    assign mem_en_o    = r_mem_en;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table of loads/stores against a byte-lane RAM model,
// plus backpressure and mid-access reset sequences.
module tb_lsu;

    logic clk_i;
    logic rst_i;
    int   n_checks;
    int   n_errors;

    lsu_if #(.ADDR_WIDTH(32)) bus ();

    lsu #(.ADDR_WIDTH(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (bus.req_valid),
        .req_ready_o  (bus.req_ready),
        .req_we_i     (bus.req_we),
        .req_funct3_i (bus.req_funct3),
        .req_addr_i   (bus.req_addr),
        .req_wdata_i  (bus.req_wdata),
        .rsp_valid_o  (bus.rsp_valid),
        .rsp_ready_i  (bus.rsp_ready),
        .rsp_rdata_o  (bus.rsp_rdata),
        .rsp_err_o    (bus.rsp_err),
        .mem_en_o     (bus.mem_en),
        .mem_we_o     (bus.mem_we),
        .mem_addr_o   (bus.mem_addr),
        .mem_wdata_o  (bus.mem_wdata),
        .mem_rdata_i  (bus.mem_rdata)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // RAM model: mask bit (3-k) writes byte k = bits[8k+7:8k]; read data one cycle after enable.
    logic [31:0] ram [0:63];
    always @(posedge clk_i) begin
        logic [31:0] w;
        if (bus.mem_en) begin
            w = ram[bus.mem_addr[7:2]];
            for (int k = 0; k < 4; k++)
                if (bus.mem_we[3-k]) w[8*k +: 8] = bus.mem_wdata[8*k +: 8];
            bus.mem_rdata <= ram[bus.mem_addr[7:2]];
            ram[bus.mem_addr[7:2]] <= w;
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  mwe;
        logic [31:0] maddr;
        logic [31:0] mwd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic [3:0] mwe, input logic [31:0] maddr,
                                input logic [31:0] mwd);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.err = 1'b0;
        v.rdata = rdata; v.mwe = mwe; v.maddr = maddr; v.mwd = mwd;
        return v;
    endfunction

    function automatic vec_t mk_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        vec_t v;
        v = mk(we, f3, addr, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0);
        v.err = 1'b1;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
    endtask

    // Wait (bounded) at negedges until the request is accepted; returns at the negedge after acceptance.
    task automatic wait_accept(input string nm, output bit ok);
        int n;
        n = 0;
        while (!bus.req_ready && n < 10) begin
            @(negedge clk_i);
            n++;
        end
        ok = bus.req_ready;
        if (!ok) check({nm, " accept timeout"}, 32'(bus.req_ready), 32'h1);
        @(negedge clk_i);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string nm;
        bit    ok;
        bit    got;
        int    lat;
        int    en_cnt;
        logic [3:0]  cwe;
        logic [31:0] caddr;
        logic [31:0] cwd;
        nm = $sformatf("v%0d", idx);
        @(negedge clk_i);
        drive_req(v.we, v.f3, v.addr, v.wdata);
        bus.rsp_ready = 1'b1;
        wait_accept(nm, ok);
        bus.req_valid = 1'b0;
        if (!ok) return;
        got = 1'b0; lat = 0; en_cnt = 0; cwe = '0; caddr = '0; cwd = '0;
        for (int c = 1; c <= 8 && !got; c++) begin
            if (c > 1) @(negedge clk_i);
            if (bus.mem_en) begin
                en_cnt++;
                cwe = bus.mem_we; caddr = bus.mem_addr; cwd = bus.mem_wdata;
            end
            if (bus.rsp_valid) begin
                got = 1'b1;
                lat = c;
            end
        end
        check({nm, " latency"}, 32'(lat), v.err ? 32'd1 : (v.we ? 32'd2 : 32'd3));
        check({nm, " mem_en cycles"}, 32'(en_cnt), v.err ? 32'd0 : 32'd1);
        if (!v.err) begin
            check({nm, " mem_we"}, 32'(cwe), 32'(v.mwe));
            check({nm, " mem_addr"}, caddr, v.maddr);
            if (v.we) check({nm, " mem_wdata"}, cwd, v.mwd);
        end
        check({nm, " rsp_err"}, 32'(bus.rsp_err), 32'(v.err));
        check({nm, " rsp_rdata"}, bus.rsp_rdata, v.rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit got;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        bus.mem_rdata  = 32'h0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.rsp_ready  = 1'b0;
        rst_i = 1'b1;

        // Vector table: stores update the RAM model, later loads read it back.
        vecs.push_back(mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 4'b1111, 32'h10, 32'hDEADBEEF));
        vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 4'b0000, 32'h10, 32'h0));
        vecs.push_back(mk(1, 3'b000, 32'h13, 32'h12345680, 32'h0, 4'b0001, 32'h10, 32'h80808080));
        vecs.push_back(mk(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 4'b0000, 32'h10, 32'h0));
        vecs.push_back(mk(0, 3'b100, 32'h13, 32'h0, 32'h00000080, 4'b0000, 32'h10, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFBE, 4'b0000, 32'h10, 32'h0));
        vecs.push_back(mk(0, 3'b100, 32'h10, 32'h0, 32'h000000EF, 4'b0000, 32'h10, 32'h0));
        vecs.push_back(mk(1, 3'b010, 32'h10, 32'h80010000, 32'h0, 4'b1111, 32'h10, 32'h80010000));
        vecs.push_back(mk(0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 4'b0000, 32'h10, 32'h0));
        vecs.push_back(mk(0, 3'b101, 32'h12, 32'h0, 32'h00008001, 4'b0000, 32'h10, 32'h0));
        vecs.push_back(mk(0, 3'b001, 32'h10, 32'h0, 32'h00000000, 4'b0000, 32'h10, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h12, 32'h0, 32'h00000001, 4'b0000, 32'h10, 32'h0));
        vecs.push_back(mk(1, 3'b001, 32'h16, 32'hCAFE1234, 32'h0, 4'b0011, 32'h14, 32'h12341234));
        vecs.push_back(mk(0, 3'b101, 32'h16, 32'h0, 32'h00001234, 4'b0000, 32'h14, 32'h0));
        vecs.push_back(mk(0, 3'b001, 32'h14, 32'h0, 32'h00000000, 4'b0000, 32'h14, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk_err(0, 3'b010, 32'h11));
        vecs.push_back(mk_err(0, 3'b001, 32'h13));
        vecs.push_back(mk_err(1, 3'b001, 32'h15));
        vecs.push_back(mk(0, 3'b010, 32'h14, 32'h0, 32'h12340000, 4'b0000, 32'h14, 32'h0));
`else
        vecs.push_back(mk(0, 3'b010, 32'h11, 32'h0, 32'h80010000, 4'b0000, 32'h10, 32'h0));
        vecs.push_back(mk(0, 3'b001, 32'h13, 32'h0, 32'hFFFF8001, 4'b0000, 32'h10, 32'h0));
        vecs.push_back(mk(1, 3'b001, 32'h15, 32'h0000ABCD, 32'h0, 4'b1100, 32'h14, 32'hABCDABCD));
        vecs.push_back(mk(0, 3'b010, 32'h14, 32'h0, 32'h1234ABCD, 4'b0000, 32'h14, 32'h0));
`endif
        vecs.push_back(mk_err(0, 3'b011, 32'h10));
        vecs.push_back(mk_err(1, 3'b100, 32'h10));
        vecs.push_back(mk_err(1, 3'b101, 32'h12));
        vecs.push_back(mk_err(0, 3'b111, 32'h10));
        vecs.push_back(mk_err(0, 3'b110, 32'h10));

        // Reset state.
        repeat (2) @(negedge clk_i);
        check("reset req_ready", 32'(bus.req_ready), 32'h0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset mem_en", 32'(bus.mem_en), 32'h0);
        check("reset mem_addr", bus.mem_addr, 32'h0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post-reset req_ready", 32'(bus.req_ready), 32'h1);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Backpressure: response must hold for 5 cycles while a competing request waits.
        @(negedge clk_i);
        drive_req(0, 3'b010, 32'h10, 32'h0);
        bus.rsp_ready = 1'b0;
        wait_accept("bp", ok);
        drive_req(1, 3'b010, 32'h20, 32'h99999999);
        got = bus.rsp_valid;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk_i);
            got = bus.rsp_valid;
        end
        check("bp rsp_valid arrives", 32'(got), 32'h1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check($sformatf("bp%0d rsp_valid", c), 32'(bus.rsp_valid), 32'h1);
            check($sformatf("bp%0d rsp_rdata", c), bus.rsp_rdata, 32'h80010000);
            check($sformatf("bp%0d rsp_err", c), 32'(bus.rsp_err), 32'h0);
            check($sformatf("bp%0d req_ready", c), 32'(bus.req_ready), 32'h0);
            check($sformatf("bp%0d mem_en", c), 32'(bus.mem_en), 32'h0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk_i);
        check("bp release rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("bp release req_ready", 32'(bus.req_ready), 32'h1);
        check("bp release no accept", 32'(bus.mem_en), 32'h0);
        bus.req_valid = 1'b0;
        @(negedge clk_i);
        check("bp idle mem_en", 32'(bus.mem_en), 32'h0);
        check("bp idle rsp_valid", 32'(bus.rsp_valid), 32'h0);

        // Reset pulse while in ACCESS: everything clears and no response follows.
        @(negedge clk_i);
        drive_req(1, 3'b010, 32'h20, 32'h11111111);
        wait_accept("rst", ok);
        bus.req_valid = 1'b0;
        check("rst in ACCESS mem_en", 32'(bus.mem_en), 32'h1);
        rst_i = 1'b1;
        #1;
        check("rst req_ready", 32'(bus.req_ready), 32'h0);
        check("rst mem_en", 32'(bus.mem_en), 32'h0);
        check("rst mem_we", 32'(bus.mem_we), 32'h0);
        check("rst mem_addr", bus.mem_addr, 32'h0);
        check("rst mem_wdata", bus.mem_wdata, 32'h0);
        check("rst rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst rsp_err", 32'(bus.rsp_err), 32'h0);
        check("rst rsp_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            if (bus.rsp_valid || bus.mem_en) got = 1'b1;
        end
        check("rst no response", 32'(got), 32'h0);
        check("rst idle req_ready", 32'(bus.req_ready), 32'h1);

        run_vec(100, mk(0, 3'b010, 32'h10, 32'h0, 32'h80010000, 4'b0000, 32'h10, 32'h0));

        repeat (2) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
